sudoku_board_ctrl: RTL and testbench
====================================

Name: sudoku_board_ctrl

Overview:
- Holds the live 9x9 Sudoku board and the editable-cell mask, and runs the menu/game stage machine.
- Drives the `stage`, `board` and `board_blank` inputs of the VGA pixel generator directly.
- Loads a puzzle from the synchronous puzzle ROM, then applies cursor moves and digit writes from the handwriting recogniser until every cell is filled.

Parameters:
- PUZZLE_CNT, 4, number of puzzles stored in ROM; each puzzle is 81 consecutive 4-bit words.
- ROM_AW, 9, puzzle ROM address width; requires PUZZLE_CNT*81 <= 2^ROM_AW.
- SEL_W, 2, width of puzzle_sel; equals clog2(PUZZLE_CNT).

Ports:
- clk  in  1  system clock; also clocks the puzzle ROM.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a puzzle load from MENU.
- back  in  1  one-cycle pulse; returns to MENU from GAME or DONE.
- puzzle_sel  in  SEL_W  puzzle index, sampled on the accepted start.
- rom_addr  out  ROM_AW  puzzle ROM read address.
- rom_data  in  4  ROM word; valid one cycle after rom_addr. 0 = blank, 1-9 = given.
- mv_up, mv_down, mv_left, mv_right  in  1 each  one-cycle cursor-move pulses.
- digit_valid  in  1  recogniser has a digit.
- digit  in  4  digit value; 0 = erase, 1-9 = write, 10-15 = invalid.
- digit_ready  out  1  controller accepts digits; 1 only in GAME.
- stage  out  1  0 = Menu, 1 = Game. Matches the pixel generator encoding.
- board  out  324  cell i = row*9+col at bits [4i+3:4i]; 0 = empty.
- board_blank  out  81  bit i = 1 means cell i is user-editable.
- cursor  out  7  cursor cell index, 0-80.
- solved  out  1  board is full; high in DONE.
- bad_digit  out  1  one-cycle pulse when an invalid or blocked digit is consumed.

Behaviour:
- Reset applies to every register and output: state MENU, board all 0, board_blank all 0, cursor 0 (row 0, col 0), ld_cnt 0, base 0, full_r 0, solved 0, bad_digit 0.
- Outputs during reset: stage 0, digit_ready 0, rom_addr 0.
- Reset mid-load aborts the load; the board is left at 0.
- All outputs except rom_addr and digit_ready are registered. rom_addr = base + ld_cnt in LOAD, else 0. digit_ready = (state == GAME).
- States: MENU (stage 0), LOAD (stage 0), GAME (stage 1), DONE (stage 1).
- MENU:
  - start -> LOAD.
  - On that edge: base <= sel*81, where sel = puzzle_sel, or 0 if puzzle_sel >= PUZZLE_CNT.
  - Also on that edge: ld_cnt <= 0, cursor <= 0.
  - Moves and digits are ignored in MENU.
- LOAD:
  - Lasts exactly 82 cycles. ld_cnt increments every edge from 0 to 81.
  - At each edge with ld_cnt >= 1: board[ld_cnt-1] <= rom_data and board_blank[ld_cnt-1] <= (rom_data == 0).
  - At the edge with ld_cnt == 81: write cell 80 and go to GAME.
  - start, back, moves and digits are ignored in LOAD.
- GAME, cursor moves:
  - Cursor row/col wrap mod 9: up from row 0 -> row 8, right from col 8 -> col 0.
  - Opposing pulses in the same cycle cancel on that axis.
- GAME, digit handshake:
  - A digit is consumed when digit_valid && digit_ready.
  - If board_blank[cursor] && digit <= 9: board[cursor] <= digit.
  - Otherwise the board is unchanged and bad_digit pulses the next cycle.
- GAME, same-cycle events:
  - Digit plus move in the same cycle: the write uses the pre-move cursor, and the move also takes effect.
  - back has priority: back with a digit -> no write, no bad_digit pulse, go to MENU.
- Full detection:
  - full_r <= (no zero nibble in board), registered every cycle.
  - GAME && full_r && !back -> DONE, and solved <= 1.
  - A write completing the board at edge N gives full_r high at N+1 and DONE at N+2.
- DONE: board is frozen; digit_ready 0. back -> MENU, solved <= 0.
- board and board_blank hold their values in MENU after back, so the last board stays displayed until the next load.
- start outside MENU is ignored.

Test Plan:
- Reset -> stage 0, board 0, board_blank 0, cursor 0, solved 0, digit_ready 0. Apply reset in the 40th LOAD cycle -> MENU with all-zero board.
- start with puzzle_sel=2, ROM word k = k mod 10:
  - rom_addr steps 162..242.
  - stage rises exactly 82 cycles after start.
  - board[0]=0, board_blank[0]=1, cell 11 = 1 with its blank bit 0.
- Cursor at 0: mv_up -> 72; mv_left -> 80; mv_right -> 72; mv_up and mv_down together -> unchanged.
- Cursor on cell 0 (blank): digit 7 valid -> cell 0 = 7.
  - digit 0 -> cell 0 = 0.
  - digit 12 -> cell unchanged, bad_digit pulse.
  - Cursor on a given cell, digit 5 -> unchanged, bad_digit pulse.
- Same-cycle events at cursor 0: digit 3 with mv_right -> cell 0 = 3, cursor 1. digit 4 with back -> no write, stage 0.
- Load a puzzle with a single blank, write its digit at edge N -> solved=1 at N+2, digit_ready 0. Further digits -> no change. back -> MENU, solved 0.

Source files
------------

// File: rtl/sudoku_board_ctrl.sv
// Sudoku board controller: holds the live 9x9 board and editable mask, loads
// puzzles from a synchronous ROM and applies cursor moves and digit writes.
module sudoku_board_ctrl #(
    parameter int PUZZLE_CNT = 4,
    parameter int ROM_AW     = 9,
    parameter int SEL_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              back,
    input  logic [SEL_W-1:0]  puzzle_sel,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    input  logic              mv_up,
    input  logic              mv_down,
    input  logic              mv_left,
    input  logic              mv_right,
    input  logic              digit_valid,
    input  logic [3:0]        digit,
    output logic              digit_ready,
    output logic              stage,
    output logic [323:0]      board,
    output logic [80:0]       board_blank,
    output logic [6:0]        cursor,
    output logic              solved,
    output logic              bad_digit
);
    // Digit handshake: a digit is consumed on any edge where digit_valid and
    // digit_ready are both high; digit_ready is high only in GAME.
    typedef enum logic [1:0] {MENU, LOAD, GAME, DONE} state_t;

    state_t            state;
    logic [3:0]        row, col, row_nx, col_nx;
    logic [6:0]        cursor_nx;
    logic [6:0]        ld_cnt, ld_idx;
    logic [ROM_AW-1:0] base, base_nx;
    logic [SEL_W-1:0]  sel_eff;
    logic              full_r, board_full, digit_ok;
    logic [8:0]        cur_bit, ld_bit;

    assign digit_ready = (state == GAME);
    assign rom_addr    = (state == LOAD) ? base + ROM_AW'(ld_cnt) : '0;
    assign sel_eff     = (32'(puzzle_sel) >= PUZZLE_CNT) ? '0 : puzzle_sel;
    assign base_nx     = ROM_AW'(sel_eff) * ROM_AW'(81);
    assign ld_idx      = ld_cnt - 7'd1;
    assign ld_bit      = {ld_idx, 2'b00};
    assign cur_bit     = {cursor, 2'b00};
    assign digit_ok    = board_blank[cursor] && (digit <= 4'd9);
    assign cursor_nx   = 7'(row_nx) * 7'd9 + 7'(col_nx);

    // Opposing pulses on one axis cancel; both axes wrap mod 9.
    always_comb begin
        row_nx = row;
        col_nx = col;
        if (mv_up && !mv_down)
            row_nx = (row == 4'd0) ? 4'd8 : row - 4'd1;
        else if (mv_down && !mv_up)
            row_nx = (row == 4'd8) ? 4'd0 : row + 4'd1;
        if (mv_left && !mv_right)
            col_nx = (col == 4'd0) ? 4'd8 : col - 4'd1;
        else if (mv_right && !mv_left)
            col_nx = (col == 4'd8) ? 4'd0 : col + 4'd1;
    end

    always_comb begin
        board_full = 1'b1;
        for (int i = 0; i < 81; i++)
            if (board[4*i +: 4] == 4'd0) board_full = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MENU;
            board       <= '0;
            board_blank <= '0;
            cursor      <= '0;
            row         <= '0;
            col         <= '0;
            ld_cnt      <= '0;
            base        <= '0;
            full_r      <= 1'b0;
            solved      <= 1'b0;
            bad_digit   <= 1'b0;
            stage       <= 1'b0;
        end else begin
            bad_digit <= 1'b0;
            // Held low through LOAD so a stale full board cannot leak into GAME.
            full_r    <= (state == LOAD) ? 1'b0 : board_full;
            case (state)
                MENU: begin
                    if (start) begin
                        state  <= LOAD;
                        base   <= base_nx;
                        ld_cnt <= '0;
                        row    <= '0;
                        col    <= '0;
                        cursor <= '0;
                    end
                end
                LOAD: begin
                    ld_cnt <= ld_cnt + 7'd1;
                    if (ld_cnt != 7'd0) begin
                        board[ld_bit +: 4]  <= rom_data;
                        board_blank[ld_idx] <= (rom_data == 4'd0);
                    end
                    if (ld_cnt == 7'd81) begin
                        state <= GAME;
                        stage <= 1'b1;
                    end
                end
                GAME: begin
                    if (back) begin
                        state <= MENU;
                        stage <= 1'b0;
                    end else begin
                        if (digit_valid) begin
                            if (digit_ok) board[cur_bit +: 4] <= digit;
                            else          bad_digit <= 1'b1;
                        end
                        row    <= row_nx;
                        col    <= col_nx;
                        cursor <= cursor_nx;
                        if (full_r) begin
                            state  <= DONE;
                            solved <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (back) begin
                        state  <= MENU;
                        stage  <= 1'b0;
                        solved <= 1'b0;
                    end
                end
                default: state <= MENU;
            endcase
        end
    end
endmodule

// File: tb/tb_sudoku_board_ctrl.sv
// Randomized bench for sudoku_board_ctrl against an array-based model of the game.
module tb_sudoku_board_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         start, back;
    logic [1:0]   puzzle_sel;
    logic [8:0]   rom_addr;
    logic [3:0]   rom_data;
    logic         mv_up, mv_down, mv_left, mv_right;
    logic         digit_valid;
    logic [3:0]   digit;
    logic         digit_ready, stage, solved, bad_digit;
    logic [323:0] board;
    logic [80:0]  board_blank;
    logic [6:0]   cursor;

    int total = 0;
    int bad   = 0;

    logic [3:0] rom_mem [0:511];
    logic [8:0] exp_q [$];

    int m_board [81];
    bit m_blank [81];
    int m_row, m_col;
    int m_state; // 0 menu, 1 game, 2 done

    sudoku_board_ctrl #(.PUZZLE_CNT(4), .ROM_AW(9), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .back(back), .puzzle_sel(puzzle_sel),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .digit_valid(digit_valid), .digit(digit), .digit_ready(digit_ready),
        .stage(stage), .board(board), .board_blank(board_blank), .cursor(cursor),
        .solved(solved), .bad_digit(bad_digit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [323:0] got, input logic [323:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [323:0] pack_board();
        logic [323:0] v = '0;
        for (int i = 0; i < 81; i++) v[4*i +: 4] = 4'(m_board[i]);
        return v;
    endfunction

    function automatic logic [80:0] pack_blank();
        logic [80:0] v = '0;
        for (int i = 0; i < 81; i++) v[i] = m_blank[i];
        return v;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < 81; i++) if (m_board[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; back = 0; mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
        digit_valid = 0; digit = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_board"}, board, pack_board());
        check({tag, "_blank"}, 324'(board_blank), 324'(pack_blank()));
        check({tag, "_cursor"}, 324'(cursor), 324'(m_row * 9 + m_col));
    endtask

    task automatic load_puzzle(input int sel);
        int n;
        int b;
        b = sel * 81;
        for (int i = 0; i < 81; i++) exp_q.push_back(9'(b + i));
        puzzle_sel = 2'(sel);
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (stage == 1'b0 && n < 200) begin
            if (exp_q.size() > 0) check("rom_addr", 324'(rom_addr), 324'(exp_q.pop_front()));
            tick();
            n++;
        end
        check("load_len", 324'(n), 324'(82));
        for (int i = 0; i < 81; i++) begin
            m_board[i] = int'(rom_mem[b + i]);
            m_blank[i] = (rom_mem[b + i] == 4'd0);
        end
        m_row = 0; m_col = 0; m_state = 1;
        check_all("load");
    endtask

    // One cycle of stimulus, then two idle cycles so full detection settles.
    task automatic op(input bit u, input bit d, input bit l, input bit r,
                      input bit dv, input logic [3:0] dg, input bit bk);
        bit exp_bad;
        int idx;
        mv_up = u; mv_down = d; mv_left = l; mv_right = r;
        digit_valid = dv; digit = dg; back = bk;
        tick();
        clear_inputs();
        exp_bad = 0;
        if (m_state == 1) begin
            if (bk) m_state = 0;
            else begin
                if (dv) begin
                    idx = m_row * 9 + m_col;
                    if (m_blank[idx] && dg <= 9) m_board[idx] = int'(dg);
                    else exp_bad = 1;
                end
                if (u && !d) m_row = (m_row + 8) % 9;
                if (d && !u) m_row = (m_row + 1) % 9;
                if (l && !r) m_col = (m_col + 8) % 9;
                if (r && !l) m_col = (m_col + 1) % 9;
            end
        end else if (m_state == 2) begin
            if (bk) m_state = 0;
        end
        check("bad_digit", 324'(bad_digit), 324'(exp_bad));
        check_all("op");
        tick();
        tick();
        if (m_state == 1 && model_full()) m_state = 2;
        check("stage", 324'(stage), 324'(m_state != 0));
        check("solved", 324'(solved), 324'(m_state == 2));
        check("digit_ready", 324'(digit_ready), 324'(m_state == 1));
    endtask

    initial begin
        for (int a = 0; a < 512; a++) rom_mem[a] = 4'((a % 81) % 10);
        for (int k = 0; k < 81; k++) rom_mem[243 + k] = (k == 40) ? 4'd0 : 4'((k % 9) + 1);
        clear_inputs();
        puzzle_sel = 0;
        for (int i = 0; i < 81; i++) begin m_board[i] = 0; m_blank[i] = 0; end
        m_row = 0; m_col = 0; m_state = 0;

        // Reset state, sampled while reset is still asserted.
        rst = 1;
        tick();
        tick();
        check("rst_stage", 324'(stage), 324'(0));
        check("rst_ready", 324'(digit_ready), 324'(0));
        check("rst_rom_addr", 324'(rom_addr), 324'(0));
        check("rst_solved", 324'(solved), 324'(0));
        check("rst_bad", 324'(bad_digit), 324'(0));
        check_all("rst");
        rst = 0;
        tick();

        // Reset in the 40th LOAD cycle aborts the load.
        puzzle_sel = 2'd2;
        start = 1;
        tick();
        start = 0;
        repeat (39) tick();
        check("midload_board_nonzero", 324'(board != '0), 324'(1));
        rst = 1;
        tick();
        rst = 0;
        check("midload_stage", 324'(stage), 324'(0));
        check("midload_rom_addr", 324'(rom_addr), 324'(0));
        check_all("midload");
        tick();
        check("midload_idle_stage", 324'(stage), 324'(0));

        // Directed load of puzzle 2 and game-play cases.
        load_puzzle(2);
        check("cell0", 324'(board[3:0]), 324'(0));
        check("blank0", 324'(board_blank[0]), 324'(1));
        check("cell11", 324'(board[47:44]), 324'(1));
        check("blank11", 324'(board_blank[11]), 324'(0));
        op(1, 0, 0, 0, 0, 0, 0);
        check("mv_up_wrap", 324'(cursor), 324'(72));
        op(0, 0, 1, 0, 0, 0, 0);
        check("mv_left_wrap", 324'(cursor), 324'(80));
        op(0, 0, 0, 1, 0, 0, 0);
        check("mv_right_wrap", 324'(cursor), 324'(72));
        op(1, 1, 0, 0, 0, 0, 0);
        check("mv_cancel", 324'(cursor), 324'(72));
        op(0, 1, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 4'd7, 0);
        check("write7", 324'(board[3:0]), 324'(7));
        op(0, 0, 0, 0, 1, 4'd0, 0);
        check("erase", 324'(board[3:0]), 324'(0));
        op(0, 0, 0, 0, 1, 4'd12, 0);
        op(0, 0, 0, 1, 0, 0, 0);
        op(0, 0, 0, 0, 1, 4'd5, 0);
        op(0, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 1, 1, 4'd3, 0);
        check("write_move_cell", 324'(board[3:0]), 324'(3));
        check("write_move_cursor", 324'(cursor), 324'(1));
        op(0, 0, 1, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 4'd4, 1);
        check("back_digit_stage", 324'(stage), 324'(0));
        check("back_digit_cell", 324'(board[3:0]), 324'(3));

        // Randomized play across puzzles 0-2.
        for (int i = 0; i < 250; i++) begin
            if (m_state == 0) load_puzzle($urandom_range(0, 2));
            else if (m_state == 2) op(0, 0, 0, 0, 0, 0, 1);
            else op($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9)),
                    $urandom_range(0, 60) == 0);
        end
        if (m_state != 0) op(0, 0, 0, 0, 0, 0, 1);

        // Single-blank puzzle: completion timing and frozen DONE board.
        load_puzzle(3);
        repeat (4) op(0, 1, 0, 1, 0, 0, 0);
        check("cursor40", 324'(cursor), 324'(40));
        digit_valid = 1;
        digit = 4'd5;
        tick();
        clear_inputs();
        m_board[40] = 5;
        check_all("fill");
        check("fill_n_solved", 324'(solved), 324'(0));
        tick();
        check("fill_n1_solved", 324'(solved), 324'(0));
        check("fill_n1_ready", 324'(digit_ready), 324'(1));
        tick();
        check("fill_n2_solved", 324'(solved), 324'(1));
        check("fill_n2_ready", 324'(digit_ready), 324'(0));
        check("fill_n2_stage", 324'(stage), 324'(1));
        m_state = 2;
        op(0, 0, 0, 0, 1, 4'd6, 0);
        op(0, 0, 0, 0, 1, 4'd0, 0);
        op(0, 0, 0, 0, 0, 0, 1);
        check("done_back_solved", 324'(solved), 324'(0));
        check("done_back_stage", 324'(stage), 324'(0));
        op(0, 0, 0, 0, 1, 4'd2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
